anc_control: RTL and testbench



---
 rtl/anc_control.sv | 150 +++++++++++++++
 tb/tb_anc_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/anc_control.sv
// +----------------------------------------------------------------------------+
// | anc_control: SSPIF-driven RAM-write / filter-start sequencer for the ANC    |
// | datapath. Optional 2-flop SSPIF synchronizer: `ANC_CTRL_SSPIF_SYNC_EN.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module anc_control #(
  parameter int RAM_EN_CYCLES    = 1,
  parameter int FILTER_DELAY     = 2,
  parameter int FILTER_EN_CYCLES = 1
) (
  input  logic Clk_100M,
  input  logic Reset,
  input  logic SSPIF,
  output logic RAMDataEN,
  output logic FilterEN
);

  localparam logic [7:0] c_ram_len    = 8'(RAM_EN_CYCLES);
  localparam logic [7:0] c_gap_len    = 8'(FILTER_DELAY);
  localparam logic [7:0] c_filter_len = 8'(FILTER_EN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAM_WR = 2'd1,
    S_GAP    = 2'd2,
    S_FILTER = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_pending;
  logic       w_pending_nxt;
  logic       r_hist;
  logic       w_sync_out;
  logic       w_edge;

  // Input flops reset to 1 so a level already high at reset release is not an edge.
`ifdef ANC_CTRL_SSPIF_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= SSPIF;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_out = r_sync2;
`else
  logic r_samp;

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_samp <= 1'b1;
    end else begin
      r_samp <= SSPIF;
    end
  end

  assign w_sync_out = r_samp;
`endif

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= w_sync_out;
    end
  end

  assign w_edge = w_sync_out & ~r_hist;

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Counter is loaded with the phase length on entry and the phase ends at 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    if (w_edge && (r_state != S_IDLE)) begin
      w_pending_nxt = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (w_edge || r_pending) begin
          w_state_nxt   = S_RAM_WR;
          w_cnt_nxt     = c_ram_len;
          w_pending_nxt = 1'b0;
        end
      end
      S_RAM_WR: begin
        if (r_cnt <= 8'd1) begin
          if (c_gap_len == 8'd0) begin
            w_state_nxt = S_FILTER;
            w_cnt_nxt   = c_filter_len;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_gap_len;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = S_FILTER;
          w_cnt_nxt   = c_filter_len;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_FILTER: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign RAMDataEN = (r_state == S_RAM_WR);
  assign FilterEN  = (r_state == S_FILTER);

endmodule

`default_nettype wire

// File: tb/tb_anc_control.sv
// Directed bench for anc_control: vector table for reset/single sample, plus
// hand-written sequences for long level, pending, mid-sequence reset and parameters.
`timescale 1ns/1ps
`default_nettype none

module tb_anc_control;

`ifdef ANC_CTRL_SSPIF_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic ssp0 = 1'b0;
  logic ssp1 = 1'b0;
  logic ram0, filt0, ram1, filt1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  anc_control dut0 (
    .Clk_100M (clk),
    .Reset    (rst),
    .SSPIF    (ssp0),
    .RAMDataEN(ram0),
    .FilterEN (filt0)
  );

  anc_control #(
    .RAM_EN_CYCLES   (4),
    .FILTER_DELAY    (0),
    .FILTER_EN_CYCLES(3)
  ) dut1 (
    .Clk_100M (clk),
    .Reset    (rst),
    .SSPIF    (ssp1),
    .RAMDataEN(ram1),
    .FilterEN (filt1)
  );

  int   ram_rises0 = 0, filt_rises0 = 0, last_ram_rise0 = 0, prev_ram_rise0 = 0;
  int   overlap = 0;
  int   ram_hi1 = 0, filt_hi1 = 0, last_ram_hi1 = -1, first_filt_hi1 = -1;
  logic ram0_q = 1'b0, filt0_q = 1'b0;

  always @(negedge clk) begin
    if (ram0 === 1'b1 && ram0_q !== 1'b1) begin
      ram_rises0++;
      prev_ram_rise0 = last_ram_rise0;
      last_ram_rise0 = cyc;
    end
    if (filt0 === 1'b1 && filt0_q !== 1'b1) filt_rises0++;
    ram0_q  = ram0;
    filt0_q = filt0;
    if ((ram0 === 1'b1 && filt0 === 1'b1) || (ram1 === 1'b1 && filt1 === 1'b1)) overlap++;
    if (ram1 === 1'b1) begin
      ram_hi1++;
      last_ram_hi1 = cyc;
    end
    if (filt1 === 1'b1) begin
      filt_hi1++;
      if (first_filt_hi1 < 0) first_filt_hi1 = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Returns at the first negedge (including the current one) where RAMDataEN is high.
  task automatic wait_ram_high(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ram0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic rst;
    logic ssp;
    logic exp_ram;
    logic exp_filt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int base_r, base_f;
    bit ok;
    logic [5:0] pat;

    // Rows 0-1 reset, 2-3 idle, SSPIF high in rows 4-8 (sampled at E0 = row 4).
    for (int k = 0; k < 16; k++) begin
      vecs[k].rst      = (k < 2);
      vecs[k].ssp      = (k >= 4) && (k <= 8);
      vecs[k].exp_ram  = (k == 4 + LAT - 1);
      vecs[k].exp_filt = (k == 4 + LAT + 2);
    end

    for (int k = 0; k < 16; k++) begin
      rst  = vecs[k].rst;
      ssp0 = vecs[k].ssp;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ram", k), ram0, vecs[k].exp_ram);
      check($sformatf("vec%0d_filt", k), filt0, vecs[k].exp_filt);
    end
    @(negedge clk);
    check("single_ram_seqs", ram_rises0, 1);
    check("single_filt_seqs", filt_rises0, 1);

    // Long level: one sequence for 600 high clocks, a second after a low gap.
    base_r = ram_rises0;
    base_f = filt_rises0;
    ssp0 = 1'b1;
    repeat (600) @(negedge clk);
    ssp0 = 1'b0;
    repeat (10) @(negedge clk);
    ssp0 = 1'b1;
    repeat (20) @(negedge clk);
    ssp0 = 1'b0;
    repeat (20) @(negedge clk);
    check("long_ram_seqs", ram_rises0 - base_r, 2);
    check("long_filt_seqs", filt_rises0 - base_f, 2);

    // Pending: rise2 is seen during GAP, rise3 while pending is still set.
    base_r = ram_rises0;
    base_f = filt_rises0;
    pat = 6'b101011;
    for (int k = 0; k < 6; k++) begin
      ssp0 = pat[k];
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    ssp0 = 1'b0;
    repeat (10) @(negedge clk);
    check("pend_ram_seqs", ram_rises0 - base_r, 2);
    check("pend_filt_seqs", filt_rises0 - base_f, 2);
    check("pend_spacing", last_ram_rise0 - prev_ram_rise0, 5);

    // Reset while FilterEN is due, with a pending edge already captured.
    base_r = ram_rises0;
    base_f = filt_rises0;
    ssp0 = 1'b1;
    @(negedge clk);
    ssp0 = 1'b0;
    @(negedge clk);
    ssp0 = 1'b1;
    wait_ram_high(20, ok);
    if (!ok) check("rstmid_wait_timeout", 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ram", ram0, 1'b0);
    check("rstmid_filt", filt0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_ram_seqs", ram_rises0 - base_r, 1);
    check("rstmid_filt_seqs", filt_rises0 - base_f, 0);
    ssp0 = 1'b0;
    repeat (5) @(negedge clk);

    // Parameterised instance: 4 RAM clocks, no gap, 3 filter clocks.
    ram_hi1        = 0;
    filt_hi1       = 0;
    first_filt_hi1 = -1;
    ssp1 = 1'b1;
    repeat (2) @(negedge clk);
    ssp1 = 1'b0;
    repeat (20) @(negedge clk);
    check("p_ram_width", ram_hi1, 4);
    check("p_filt_width", filt_hi1, 3);
    check("p_filt_follows", first_filt_hi1 - last_ram_hi1, 1);

    check("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
